// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bundle of the CPU, DMA and memory buses around the arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a single-port synchronous memory
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              dma_own_q, dma_own_d;
    logic              last_dma_q, last_dma_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic              any_req;
    logic              pick_dma;
    logic              mem_en;
    logic              mem_we;
    logic              cpu_ack;
    logic              dma_ack;

    // DMA wins when it asks alone, or on a tie when the CPU was served last.
    always_comb begin
        any_req  = bus.cpu_req | bus.dma_req;
        pick_dma = bus.dma_req & (~bus.cpu_req | ~last_dma_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dma_own_q   <= 1'b0;
            last_dma_q  <= 1'b1;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dma_own_q   <= dma_own_d;
            last_dma_q  <= last_dma_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dma_own_d   = dma_own_q;
        last_dma_d  = last_dma_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        cpu_ack     = 1'b0;
        dma_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = ACCESS;
                    dma_own_d  = pick_dma;
                    last_dma_d = pick_dma;
                    we_d       = pick_dma ? bus.dma_we    : bus.cpu_we;
                    addr_d     = pick_dma ? bus.dma_addr  : bus.cpu_addr;
                    wdata_d    = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
                end
            end
            ACCESS: begin
                mem_en  = 1'b1;
                mem_we  = we_q;
                state_d = RESP;
            end
            RESP: begin
                cpu_ack = ~dma_own_q;
                dma_ack = dma_own_q;
                state_d = IDLE;
                // Read data is passed through combinationally so it is valid alongside ack.
                if (!we_q) begin
                    if (dma_own_q) begin
                        dma_rdata_d = bus.mem_rdata;
                    end else begin
                        cpu_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = cpu_ack;
    assign bus.dma_ack   = dma_ack;
    assign bus.cpu_rdata = cpu_rdata_d;
    assign bus.dma_rdata = dma_rdata_d;
    assign bus.busy      = (state_q != IDLE);
endmodule
